simd_sat_alu: RTL and testbench

- Parametrised, pipelined SIMD saturating add/subtract unit.
- Splits two DATA_W operands into LANES independent lanes of LANE_W bits each. Every lane is added or subtracted with signed or unsigned saturation.
- Generalises the fixed 4x4-bit saturating packed add used by the ALU. Adds subtract and unsigned modes, a 2-stage valid/ready pipeline, per-result saturation flags and sticky status.
- Sits between the register-read stage and the ALU result mux for packed-arithmetic instructions.

---
 rtl/simd_sat_alu.sv | 100 ++++++++++
 tb/tb_simd_sat_alu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_sat_alu.sv
// Two-stage SIMD saturating add/subtract: S1 holds raw (LANE_W+1)-bit lane results,
// S2 holds the clamped packed result and per-lane saturation flags.
module simd_sat_alu #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int DATA_W = LANE_W * LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd,
    output logic [LANES-1:0]  out_sat,
    input  logic              clr_flags,
    output logic [LANES-1:0]  sat_flags
);

    logic                         s1_valid;
    logic                         s1_ready;
    logic                         s2_ready;
    logic [1:0]                   s1_op;
    logic [LANES-1:0][LANE_W:0]   raw_c;
    logic [LANES-1:0][LANE_W:0]   s1_raw;
    logic [DATA_W-1:0]            rd_c;
    logic [LANES-1:0]             sat_c;

    assign s2_ready = ~out_valid | out_ready;
    assign s1_ready = ~s1_valid | s2_ready;
    assign in_ready = s1_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
        logic [LANE_W:0]   a_x;
        logic [LANE_W:0]   b_x;
        logic [LANE_W:0]   r;
        logic [LANE_W-1:0] lane_rd;
        logic              lane_sat;

        assign a   = rs[g*LANE_W +: LANE_W];
        assign b   = rt[g*LANE_W +: LANE_W];
        // op[1] selects unsigned (zero-extend) vs signed (sign-extend)
        assign a_x = op[1] ? {1'b0, a} : {a[LANE_W-1], a};
        assign b_x = op[1] ? {1'b0, b} : {b[LANE_W-1], b};
        assign raw_c[g] = op[0] ? (a_x - b_x) : (a_x + b_x);

        assign r = s1_raw[g];

        always_comb begin
            lane_rd  = r[LANE_W-1:0];
            lane_sat = 1'b0;
            if (!s1_op[1]) begin
                if (r[LANE_W] != r[LANE_W-1]) begin
                    lane_sat = 1'b1;
                    lane_rd  = r[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                         : {1'b0, {(LANE_W-1){1'b1}}};
                end
            end else if (r[LANE_W]) begin
                // carry-out on add clamps high, borrow on sub clamps to zero
                lane_sat = 1'b1;
                lane_rd  = s1_op[0] ? '0 : '1;
            end
        end

        assign rd_c[g*LANE_W +: LANE_W] = lane_rd;
        assign sat_c[g]                 = lane_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            rd        <= '0;
            out_sat   <= '0;
            sat_flags <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_raw <= raw_c;
                    s1_op  <= op;
                end
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    rd      <= rd_c;
                    out_sat <= sat_c;
                end
            end
            sat_flags <= (clr_flags ? '0 : sat_flags) | ((out_valid && out_ready) ? out_sat : '0);
        end
    end

endmodule

// File: tb/tb_simd_sat_alu.sv
// Self-checking bench for simd_sat_alu: directed vectors, backpressure, sticky flags,
// mid-stream reset and randomized traffic against an integer-arithmetic reference model.
module tb_simd_sat_alu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, clr_flags;
    logic [1:0]  op;
    logic [15:0] rs, rt, rd;
    logic [3:0]  out_sat, sat_flags;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, clr_flags8;
    logic [1:0]  op8;
    logic [15:0] rs8, rt8, rd8;
    logic [1:0]  out_sat8, sat_flags8;

    simd_sat_alu u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs(rs), .rt(rt), .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
        .out_sat(out_sat), .clr_flags(clr_flags), .sat_flags(sat_flags)
    );

    simd_sat_alu #(.LANE_W(8), .LANES(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .rs(rs8), .rt(rt8), .out_valid(out_valid8), .out_ready(out_ready8), .rd(rd8),
        .out_sat(out_sat8), .clr_flags(clr_flags8), .sat_flags(sat_flags8)
    );

    typedef struct packed {
        logic [15:0] rd;
        logic [3:0]  sat;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    logic [3:0]  f_model = 4'h0;
    logic        got_out, accepted, held = 1'b0, last_in_ready;
    logic [15:0] last_rd, held_rd;
    logic [3:0]  last_sat, held_sat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference: per-lane integer arithmetic with range clamping.
    function automatic void model(input int lw, input int n, input logic [1:0] o,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r_out, output logic [7:0] s_out);
        int x, y, r, lo, hi, full;
        full  = 1 << lw;
        r_out = '0;
        s_out = '0;
        for (int i = 0; i < n; i++) begin
            x = int'((a >> (i * lw)) & 32'(full - 1));
            y = int'((b >> (i * lw)) & 32'(full - 1));
            if (!o[1]) begin
                if (x >= full / 2) x -= full;
                if (y >= full / 2) y -= full;
                lo = -(full / 2);
                hi = full / 2 - 1;
            end else begin
                lo = 0;
                hi = full - 1;
            end
            r = o[0] ? x - y : x + y;
            if (r > hi) begin
                r = hi;
                s_out[i] = 1'b1;
            end else if (r < lo) begin
                r = lo;
                s_out[i] = 1'b1;
            end
            r_out |= (32'(r) & 32'(full - 1)) << (i * lw);
        end
    endfunction

    // One clock of the main DUT: observe transfers at negedge, check sticky flags after the edge.
    task automatic cycle();
        exp_t        e;
        logic [31:0] mrd;
        logic [7:0]  msat;
        logic [3:0]  fn;
        @(negedge clk);
        got_out       = 1'b0;
        accepted      = 1'b0;
        last_in_ready = in_ready;
        if (held && out_valid) begin
            chk("hold_rd", 32'(rd), 32'(held_rd));
            chk("hold_sat", 32'(out_sat), 32'(held_sat));
        end
        held     = out_valid && !out_ready;
        held_rd  = rd;
        held_sat = out_sat;
        fn = clr_flags ? 4'h0 : f_model;
        if (q.size() == 0) begin
            chk("stale_beat", 32'(out_valid), 32'(0));
        end else if (out_valid && out_ready) begin
            got_out  = 1'b1;
            last_rd  = rd;
            last_sat = out_sat;
            e = q.pop_front();
            chk("rd", 32'(rd), 32'(e.rd));
            chk("out_sat", 32'(out_sat), 32'(e.sat));
            fn |= e.sat;
        end
        if (in_valid && in_ready) begin
            accepted = 1'b1;
            model(4, 4, op, 32'(rs), 32'(rt), mrd, msat);
            q.push_back({mrd[15:0], msat[3:0]});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            fn   = 4'h0;
            held = 1'b0;
        end
        f_model = fn;
        chk("sat_flags", 32'(sat_flags), 32'(f_model));
    endtask

    task automatic directed(input string tag, input logic [1:0] o, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] er, input logic [3:0] es);
        int n;
        op = o; rs = a; rt = b; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk({tag, "_acc"}, 32'(accepted), 32'(1));
        in_valid = 1'b0;
        n = 0;
        got_out = 1'b0;
        while (!got_out && n < 10) begin
            cycle();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(2));
        chk({tag, "_rd"}, 32'(last_rd), 32'(er));
        chk({tag, "_sat"}, 32'(last_sat), 32'(es));
    endtask

    task automatic beat8(input string tag, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic [1:0] es);
        int          n;
        logic [31:0] mrd;
        logic [7:0]  msat;
        model(8, 2, o, 32'(a), 32'(b), mrd, msat);
        op8 = o; rs8 = a; rt8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready8), 32'(1));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid8 && n < 10);
        chk({tag, "_lat"}, 32'(n), 32'(2));
        chk({tag, "_rd"}, 32'(rd8), 32'(er));
        chk({tag, "_sat"}, 32'(out_sat8), 32'(es));
        chk({tag, "_model_rd"}, 32'(rd8), 32'(mrd[15:0]));
        chk({tag, "_model_sat"}, 32'(out_sat8), 32'(msat[1:0]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, nout;
        logic [15:0] bp_rs[3];
        logic [15:0] bp_rt[3];

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0; op = 2'b00; rs = '0; rt = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; clr_flags8 = 1'b0; op8 = 2'b00; rs8 = '0; rt8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_rd", 32'(rd), 32'(0));
        chk("rst_sat_flags", 32'(sat_flags), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;

        directed("add_all_sat", 2'b00, 16'h7777, 16'h1111, 16'h7777, 4'hF);
        directed("add_mix",     2'b00, 16'h7F21, 16'h1F13, 16'h7E34, 4'b1000);
        directed("add_neg_sat", 2'b00, 16'h8888, 16'h8888, 16'h8888, 4'hF);
        directed("add_exact",   2'b00, 16'h7000, 16'h0000, 16'h7000, 4'h0);
        directed("ssub",        2'b01, 16'h8070, 16'h1F0F, 16'h8171, 4'b1000);
        directed("usub",        2'b11, 16'h1234, 16'h2222, 16'h0012, 4'b1000);
        directed("uadd",        2'b10, 16'hF9F0, 16'h1101, 16'hFAF1, 4'b1000);

        // Backpressure: three beats offered while the sink stalls.
        bp_rs[0] = 16'h1111; bp_rt[0] = 16'h2222;
        bp_rs[1] = 16'h7000; bp_rt[1] = 16'h1000;
        bp_rs[2] = 16'h0101; bp_rt[2] = 16'h0101;
        out_ready = 1'b0;
        op = 2'b00;
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rs = bp_rs[k]; rt = bp_rt[k];
            cycle();
            if (accepted) k++;
        end
        chk("bp_accepted", 32'(k), 32'(2));
        chk("bp_in_ready", 32'(last_in_ready), 32'(0));
        out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 3; c++) begin
            if (k < 3) begin
                in_valid = 1'b1; rs = bp_rs[k]; rt = bp_rt[k];
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (accepted) k++;
            if (got_out) nout++;
        end
        in_valid = 1'b0;
        chk("bp_accepted_all", 32'(k), 32'(3));
        chk("bp_drain_rate", 32'(nout), 32'(3));

        // Sticky flags: clear and set landing in the same cycle.
        clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;
        chk("sticky_clr", 32'(sat_flags), 32'(0));
        directed("sticky_set", 2'b00, 16'h7000, 16'h1000, 16'h7000, 4'b1000);
        chk("sticky_acc", 32'(sat_flags), 32'(4'b1000));
        op = 2'b00; rs = 16'h0007; rt = 16'h0001; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;
        chk("sticky_xfer", 32'(got_out), 32'(1));
        chk("sticky_clr_set", 32'(sat_flags), 32'(4'b0001));

        // Reset with two beats in flight and the sink stalled.
        out_ready = 1'b0;
        op = 2'b00; rs = 16'h7777; rt = 16'h7777; in_valid = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("mrst_out_valid", 32'(out_valid), 32'(0));
        chk("mrst_rd", 32'(rd), 32'(0));
        chk("mrst_out_sat", 32'(out_sat), 32'(0));
        chk("mrst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();

        // Randomized traffic with random stalls and occasional flag clears.
        accepted = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (accepted || !in_valid) begin
                op = 2'($urandom());
                rs = 16'($urandom());
                rt = 16'($urandom());
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 15) == 0);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (5) cycle();
        chk("drain_empty", 32'(q.size()), 32'(0));

        beat8("w8_sadd", 2'b00, 16'h7F80, 16'h01FF, 16'h7F80, 2'b11);
        beat8("w8_uadd", 2'b10, 16'hFF01, 16'h0102, 16'hFF03, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
